// File: rtl/sram_be_dp_if.sv
// Bus bundle for the byte-enable dual-port memory: one write port, one read port,
// registered read data with a valid strobe, and a busy flag from the clear engine.
interface sram_be_dp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = DATA_W / 8;

  // Handshake: a write or read is taken on any rising edge where ce & we (or ce & re)
  // is high and busy_o is low; there is no backpressure beyond busy_o, and rvalid_o
  // is high for exactly the one cycle after an accepted read, qualifying data_o.
  logic              ce;
  logic              we;
  logic [ADDR_W-1:0] waddr_i;
  logic [NB-1:0]     sel_i;
  logic [DATA_W-1:0] data_i;
  logic              re;
  logic [ADDR_W-1:0] raddr_i;
  logic [DATA_W-1:0] data_o;
  logic              rvalid_o;
  logic              busy_o;

  modport master (
    output ce, we, waddr_i, sel_i, data_i, re, raddr_i,
    input  data_o, rvalid_o, busy_o
  );

  modport slave (
    input  ce, we, waddr_i, sel_i, data_i, re, raddr_i,
    output data_o, rvalid_o, busy_o
  );
endinterface

// File: rtl/sram_be_dp.sv
// Byte-enable memory with independent write and read ports, write-first bypass,
// one-cycle registered read and a post-reset clear engine that zeroes every word.
module sram_be_dp #(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 256,
  parameter int ADDR_W         = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  sram_be_dp_if.slave  bus,
  output logic         dbg_state
);
  localparam int NB    = DATA_W / 8;
  localparam int LSB   = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {
    ST_READY = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam state_t RST_STATE = state_t'(CLEAR_ON_RESET);

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  cnt;
  logic [IDX_W-1:0]  cnt_nxt;
  logic              clr_we;
  logic              busy;
  logic              wr_en;
  logic              rd_en;
  logic [IDX_W-1:0]  widx;
  logic [IDX_W-1:0]  ridx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] data_q;
  logic              rvalid_q;
  logic              unused_addr_bits;

  // Address bits outside the word-index field are deliberately ignored (aliasing).
  assign widx             = bus.waddr_i[LSB +: IDX_W];
  assign ridx             = bus.raddr_i[LSB +: IDX_W];
  assign unused_addr_bits = ^{bus.waddr_i, bus.raddr_i};

  assign busy  = (state == ST_CLEAR);
  assign wr_en = rst_n && bus.ce && bus.we && !busy;
  assign rd_en = rst_n && bus.ce && bus.re && !busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_we    = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_we  = rst_n;
        cnt_nxt = cnt + 1'b1;
        if (cnt == IDX_W'(DEPTH - 1)) begin
          state_nxt = ST_READY;
        end
      end
      default: begin
        state_nxt = ST_READY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (bus.sel_i[k]) begin
          mem[widx][8*k +: 8] <= bus.data_i[8*k +: 8];
        end
      end
    end
  end

  // Write-first: enabled bytes of a same-index write replace the stored bytes.
  always_comb begin
    rd_word = mem[ridx];
    if (wr_en && (widx == ridx)) begin
      for (int k = 0; k < NB; k++) begin
        if (bus.sel_i[k]) begin
          rd_word[8*k +: 8] = bus.data_i[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_en;
      if (rd_en) begin
        data_q <= rd_word;
      end
    end
  end

  assign bus.data_o   = data_q;
  assign bus.rvalid_o = rvalid_q;
  assign bus.busy_o   = busy;
  assign dbg_state    = state;
endmodule
